cdc_request_arbiter: RTL
========================

// Module: cdc_request_arbiter
//
// PURPOSE
// Shares one four-phase req/ack clock-domain-crossing channel between
// NUM_REQUESTERS local clients in the clk domain.
// - Picks one client round-robin and captures its data word.
// - Drives xfer_req_o / xfer_data_o and waits for the remote domain's
//   asynchronous xfer_ack_i, brought in through a synchronizer.
// - Completes the full req/ack return-to-zero sequence before
//   arbitrating again.
// Sits between on-chip masters (debug, perf counters, host I/O) and a
// slower or unrelated external clock domain.
//
// PARAMETERS
// NUM_REQUESTERS  4   number of local clients, >= 2
// DATA_WIDTH      32  width of the word carried per transfer
//
// PORTS
// clk            in   1                  clock
// reset          in   1                  synchronous, active-high reset
// request_i      in   NUM_REQUESTERS     per-client transfer request (level)
// request_data_i in   NUM_REQUESTERS*DW  packed data, client n at [n*DW +: DW]
// grant_o        out  NUM_REQUESTERS     one-hot, 1-cycle pulse: transfer acked
// busy_o         out  1                  state != IDLE
// xfer_req_o     out  1                  four-phase request to remote domain
// xfer_data_o    out  DATA_WIDTH         captured word; stable while req or ack high
// xfer_src_o     out  $clog2(NUM_REQ)    index of client being served
// xfer_ack_i     in   1                  remote acknowledge, asynchronous to clk
//
// BEHAVIOUR
// - Reset state: IDLE. xfer_req_o=0, grant_o=0, busy_o=0, xfer_data_o=0,
//   xfer_src_o=0, round-robin pointer at client 0. Synchronizer flops reset to 0.
// - ack_sync: xfer_ack_i through a 3-flop synchronizer.
//   3 clk edges of latency from a stable xfer_ack_i.
// - IDLE, any request_i bit set and ack_sync==0:
//   - Pick a client round-robin, starting after the last one granted.
//   - Capture its data and index into xfer_data_o / xfer_src_o.
//   - Go to REQ. xfer_req_o is registered high from the next cycle.
// - IDLE with ack_sync==1 (stale ack after reset): no arbitration until it reads 0.
// - REQ: hold xfer_req_o=1. When ack_sync==1:
//   - grant_o[xfer_src_o]=1 for this cycle only (decoded from registered
//     state and ack_sync).
//   - Advance the round-robin pointer; go to RELEASE.
// - RELEASE: xfer_req_o=0. When ack_sync==0, go to IDLE.
//   Minimum cycle from request to next arbitration = 1 + 3 + 1 + 3 + 1
//   with an immediate remote ack.
// - xfer_data_o and xfer_src_o change only in IDLE on arbitration.
//   They never change while xfer_req_o or ack_sync is high.
// - Clients must hold request_i until their grant pulse.
//   - A request dropped after capture does not abort the transfer.
//   - Its grant pulse still fires.
// - A client holding request_i through its grant is served again only
//   after all other active requesters.
// - No timeout: a remote side that never acks stalls in REQ indefinitely.
// - Reset mid-transfer (REQ or RELEASE): the next cycle is IDLE with
//   xfer_req_o=0 and no grant pulse. A pending remote ack is drained via the
//   ack_sync==0 gate in IDLE.
//
// STRUCTURE
// - State enum {IDLE, REQ, RELEASE} is local to this module.
// - Nothing is added to the shared defines package: widths derive from the
//   parameters.
// - Sub-modules:
//   - synchronizer (WIDTH=1, RESET_STATE=0) for xfer_ack_i.
//   - rr_arbiter (NUM_REQUESTERS): request vector, one-hot grant, pointer
//     update on the grant pulse.
//
// TESTING
// 1. xfer_ack_i=1 through reset, request_i=4'b0001 ->
//    xfer_req_o stays 0 until 3 cycles after ack falls, then one transfer.
// 2. Client 2 requests with data 32'hDEADBEEF, remote acks 2 clk after req ->
//    xfer_data_o=DEADBEEF, xfer_src_o=2, single grant_o=4'b0100 pulse,
//    req falls the next cycle.
// 3. request_i=4'b1111 held, auto-ack model ->
//    grants in order 0,1,2,3,0,1, never two bits set at once.
// 4. Client 1 drops request_i while in REQ ->
//    transfer completes, grant_o=4'b0010 still pulses once.
// 5. reset asserted in REQ ->
//    xfer_req_o=0 next cycle, no grant, next transfer waits for ack_sync=0.
// 6. Change request_data_i every cycle during REQ/RELEASE ->
//    xfer_data_o constant until the next IDLE arbitration.

Source files
------------

// File: rtl/cdc_request_arbiter_pkg.sv
// cdc_request_arbiter_pkg: shared constants for the request arbiter and its ack synchronizer
package cdc_request_arbiter_pkg;
  localparam int SYNC_STAGES = 3;
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
endpackage

// File: rtl/cdc_request_arbiter_rr.sv
// rr_arbiter: round-robin selection whose priority pointer moves past the client just served
module rr_arbiter
  import cdc_request_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  request,
  input  logic          advance,
  input  logic [IW-1:0] served,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (advance) ptr <= (served == IW'(N - 1)) ? '0 : served + 1'b1;
  end
  // first requester at or after the pointer, wrapping around
  always_comb begin
    any = 1'b0;
    grant_idx = '0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && request[cand]) begin
        any = 1'b1;
        grant_idx = cand;
      end
    end
  end
  assign grant = any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
endmodule

// File: rtl/cdc_request_arbiter_sync.sv
// synchronizer: multi-flop synchronizer bringing an asynchronous signal into the clk domain
module synchronizer
  import cdc_request_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_STATE = '0,
  parameter int STAGES = SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [STAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RESET_STATE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end
  assign q = stage[STAGES-1];
endmodule

// File: rtl/cdc_request_arbiter.sv
// cdc_request_arbiter: shares one four-phase req/ack CDC channel between local clients, round-robin
module cdc_request_arbiter
  import cdc_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IW = $clog2(NUM_REQUESTERS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQUESTERS-1:0]          request_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data_i,
  output logic [NUM_REQUESTERS-1:0]          grant_o,
  output logic                               busy_o,
  output logic                               xfer_req_o,
  output logic [DATA_WIDTH-1:0]              xfer_data_o,
  output logic [IW-1:0]                      xfer_src_o,
  input  logic                               xfer_ack_i
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t state, state_n;
  logic ack_sync, pick_any, launch, acked, settled;
  logic [NUM_REQUESTERS-1:0] pick;
  logic [IW-1:0] pick_idx;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [WARM_W-1:0] warm;
  synchronizer #(.WIDTH(1), .RESET_STATE(1'b0)) u_ack_sync (
    .clk(clk), .reset(reset), .d(xfer_ack_i), .q(ack_sync)
  );
  rr_arbiter #(.N(NUM_REQUESTERS)) u_rr (
    .clk(clk), .reset(reset), .request(request_i), .advance(acked), .served(xfer_src_o),
    .grant(pick), .grant_idx(pick_idx), .any(pick_any)
  );
  always_comb begin
    pick_data = '0;
    for (int n = 0; n < NUM_REQUESTERS; n++)
      pick_data |= request_data_i[n*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{pick[n]}};
  end
  // synchronizer flops clear on reset, so ack_sync is untrustworthy until they have refilled
  assign settled = warm == WARM_W'(SYNC_STAGES);
  assign launch = state == IDLE && settled && !ack_sync && pick_any;
  assign acked = state == REQ && ack_sync;
  always_comb begin
    state_n = launch ? REQ
            : acked ? RELEASE
            : (state == RELEASE && !ack_sync) ? IDLE
            : state;
  end
  assign grant_o = acked ? ({{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << xfer_src_o) : '0;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      xfer_req_o <= 1'b0;
      xfer_data_o <= '0;
      xfer_src_o <= '0;
      warm <= '0;
    end else begin
      state <= state_n;
      xfer_req_o <= state_n == REQ;
      if (launch) begin
        xfer_data_o <= pick_data;
        xfer_src_o <= pick_idx;
      end
      if (!settled) warm <= warm + 1'b1;
    end
  end
endmodule
